// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the I/D cache memory block arbiter.
package mem_arb_pkg;

   localparam int BLK_W    = 256;
   localparam int OFF_BITS = 5;

   typedef enum logic [2:0] {
      IDLE,
      I_RD,
      D_RD,
      D_WR,
      RESP
   } arbState_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grantSide_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick between the I and D requesters.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic       req_i,
   input  logic       req_d,
   input  grantSide_t last_grant,
   output grantSide_t grant
);

   // On a tie the side that was not granted last wins.
   always_comb begin
      grant = GRANT_I;
      if (req_i && req_d) begin
         grant = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
      end else if (req_d) begin
         grant = GRANT_D;
      end
   end

endmodule

// File: rtl/mem_block_arbiter.sv
// Arbitrates I-cache refills and D-cache refills/writebacks onto one block memory port.
// Handshake: a request is held until its done pulse; memory valids are honoured only in the matching grant state.
module mem_block_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int BLK_W    = mem_arb_pkg::BLK_W,
   parameter int OFF_BITS = mem_arb_pkg::OFF_BITS
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              iReq_fIC,
   input  logic [ADDR_W-1:0] iAddr_fIC,
   output logic [BLK_W-1:0]  iBlock_2IC,
   output logic              iDone_2IC,
   input  logic              dRead_fDC,
   input  logic              dWrite_fDC,
   input  logic [ADDR_W-1:0] dAddr_fDC,
   input  logic [BLK_W-1:0]  dBlock_fDC,
   output logic [BLK_W-1:0]  dBlock_2DC,
   output logic              dDone_2DC,
   output logic [ADDR_W-1:0] blk_address_2M,
   output logic              BlkRead_2M,
   output logic              BlkWrite_2M,
   output logic [BLK_W-1:0]  block_write_2M,
   input  logic [BLK_W-1:0]  block_read_fM,
   input  logic              block_read_fM_valid,
   input  logic              block_write_fM_valid,
   output logic              busy
);

   import mem_arb_pkg::*;

   arbState_t         state, nextState;
   grantSide_t        lastGrant, grant;
   logic              respIsD;
   logic              dReq, anyReq;
   logic [ADDR_W-1:0] addrReg;
   logic [BLK_W-1:0]  wrDataReg, iBlockReg, dBlockReg;

   assign dReq   = dRead_fDC | dWrite_fDC;
   assign anyReq = iReq_fIC | dReq;

   rr_pick2 uPick (
      .req_i      (iReq_fIC),
      .req_d      (dReq),
      .last_grant (lastGrant),
      .grant      (grant)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= nextState;
   end

   // Writeback beats refill on the D side; the read stays pending for a later grant.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (anyReq) begin
               if (grant == GRANT_I)  nextState = I_RD;
               else if (dWrite_fDC)   nextState = D_WR;
               else                   nextState = D_RD;
            end
         end
         I_RD, D_RD: if (block_read_fM_valid)  nextState = RESP;
         D_WR:       if (block_write_fM_valid) nextState = RESP;
         RESP:       nextState = IDLE;
         default:    nextState = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         lastGrant <= GRANT_D;
         respIsD   <= 1'b0;
         addrReg   <= '0;
         wrDataReg <= '0;
         iBlockReg <= '0;
         dBlockReg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (anyReq) begin
                  lastGrant <= grant;
                  respIsD   <= (grant == GRANT_D);
                  if (grant == GRANT_I) begin
                     addrReg <= {iAddr_fIC[ADDR_W-1:OFF_BITS], {OFF_BITS{1'b0}}};
                  end else begin
                     addrReg <= {dAddr_fDC[ADDR_W-1:OFF_BITS], {OFF_BITS{1'b0}}};
                     if (dWrite_fDC) wrDataReg <= dBlock_fDC;
                  end
               end
            end
            I_RD: if (block_read_fM_valid) iBlockReg <= block_read_fM;
            D_RD: if (block_read_fM_valid) dBlockReg <= block_read_fM;
            default: ;
         endcase
      end
   end

   assign BlkRead_2M     = (state == I_RD) || (state == D_RD);
   assign BlkWrite_2M    = (state == D_WR);
   assign blk_address_2M = addrReg;
   assign block_write_2M = wrDataReg;
   assign iBlock_2IC     = iBlockReg;
   assign dBlock_2DC     = dBlockReg;
   assign iDone_2IC      = (state == RESP) && !respIsD;
   assign dDone_2DC      = (state == RESP) && respIsD;
   assign busy           = (state != IDLE);

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Directed bench for mem_block_arbiter: memory responder tasks plus a done-pulse scoreboard.
module tb_mem_block_arbiter;

   import mem_arb_pkg::*;

   localparam int ADDR_W = 32;

   logic              CLK = 1'b0;
   logic              RESET;
   logic              iReq_fIC;
   logic [ADDR_W-1:0] iAddr_fIC;
   logic [BLK_W-1:0]  iBlock_2IC;
   logic              iDone_2IC;
   logic              dRead_fDC;
   logic              dWrite_fDC;
   logic [ADDR_W-1:0] dAddr_fDC;
   logic [BLK_W-1:0]  dBlock_fDC;
   logic [BLK_W-1:0]  dBlock_2DC;
   logic              dDone_2DC;
   logic [ADDR_W-1:0] blk_address_2M;
   logic              BlkRead_2M;
   logic              BlkWrite_2M;
   logic [BLK_W-1:0]  block_write_2M;
   logic [BLK_W-1:0]  block_read_fM;
   logic              block_read_fM_valid;
   logic              block_write_fM_valid;
   logic              busy;

   mem_block_arbiter #(
      .ADDR_W   (ADDR_W),
      .BLK_W    (BLK_W),
      .OFF_BITS (OFF_BITS)
   ) dut (
      .CLK                  (CLK),
      .RESET                (RESET),
      .iReq_fIC             (iReq_fIC),
      .iAddr_fIC            (iAddr_fIC),
      .iBlock_2IC           (iBlock_2IC),
      .iDone_2IC            (iDone_2IC),
      .dRead_fDC            (dRead_fDC),
      .dWrite_fDC           (dWrite_fDC),
      .dAddr_fDC            (dAddr_fDC),
      .dBlock_fDC           (dBlock_fDC),
      .dBlock_2DC           (dBlock_2DC),
      .dDone_2DC            (dDone_2DC),
      .blk_address_2M       (blk_address_2M),
      .BlkRead_2M           (BlkRead_2M),
      .BlkWrite_2M          (BlkWrite_2M),
      .block_write_2M       (block_write_2M),
      .block_read_fM        (block_read_fM),
      .block_read_fM_valid  (block_read_fM_valid),
      .block_write_fM_valid (block_write_fM_valid),
      .busy                 (busy)
   );

   // ---------------- clock / reset ----------------
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [BLK_W:0]   exp_q[$];
   logic [BLK_W:0]   monE;
   logic [BLK_W-1:0] modelI, modelD;
   int checks   = 0;
   int failures = 0;

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic checkW(input string tag, input logic [BLK_W-1:0] obs, input logic [BLK_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkI(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [BLK_W-1:0] randBlk();
      logic [BLK_W-1:0] r;
      for (int k = 0; k < BLK_W / 32; k++) r[k*32 +: 32] = $urandom();
      return r;
   endfunction

   function automatic logic [ADDR_W-1:0] blkAddr(input logic [ADDR_W-1:0] a);
      return a & ~((ADDR_W'(1) << OFF_BITS) - ADDR_W'(1));
   endfunction

   task automatic expectDone(input logic isD, input logic [BLK_W-1:0] blk);
      exp_q.push_back({isD, blk});
   endtask

   // Every done pulse must match the oldest expected completion.
   always @(negedge CLK) begin
      if (!RESET && (iDone_2IC || dDone_2DC)) begin
         if (exp_q.size() == 0) begin
            checkI("done_unexpected", {30'd0, iDone_2IC, dDone_2DC}, 0);
         end else begin
            monE = exp_q.pop_front();
            check1("done_side_i", iDone_2IC, !monE[BLK_W]);
            check1("done_side_d", dDone_2DC, monE[BLK_W]);
            if (monE[BLK_W]) checkW("done_dblock", dBlock_2DC, monE[BLK_W-1:0]);
            else             checkW("done_iblock", iBlock_2IC, monE[BLK_W-1:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic checkIdleOutputs(input string tag);
      check1({tag, "_busy"},   busy, 1'b0);
      check1({tag, "_rd"},     BlkRead_2M, 1'b0);
      check1({tag, "_wr"},     BlkWrite_2M, 1'b0);
      check1({tag, "_idone"},  iDone_2IC, 1'b0);
      check1({tag, "_ddone"},  dDone_2DC, 1'b0);
      checkW({tag, "_addr"},   BLK_W'(blk_address_2M), '0);
      checkW({tag, "_wdata"},  block_write_2M, '0);
      checkW({tag, "_iblock"}, iBlock_2IC, '0);
      checkW({tag, "_dblock"}, dBlock_2DC, '0);
   endtask

   task automatic waitGrant();
      int n = 0;
      while (!(BlkRead_2M || BlkWrite_2M) && n < 20) begin
         @(negedge CLK);
         n++;
      end
      check1("grant_timeout", n < 20, 1'b1);
   endtask

   // Acts as memory: waits for the grant, checks the request, then answers after waitCycles.
   task automatic serve(input logic isWrite, input logic [ADDR_W-1:0] expAddr,
                        input logic [BLK_W-1:0] expWr, input int waitCycles,
                        input logic [BLK_W-1:0] rdData, input logic noise);
      waitGrant();
      check1("blk_read", BlkRead_2M, !isWrite);
      check1("blk_write", BlkWrite_2M, isWrite);
      checkW("mem_addr", BLK_W'(blk_address_2M), BLK_W'(expAddr));
      if (isWrite) checkW("mem_wdata", block_write_2M, expWr);
      for (int k = 0; k < waitCycles; k++) begin
         if (noise) begin
            if (isWrite) block_read_fM_valid = 1'b1;
            else         block_write_fM_valid = 1'b1;
            block_read_fM = randBlk();
            dAddr_fDC     = dAddr_fDC + 32'h100;
            dBlock_fDC    = randBlk();
         end
         @(negedge CLK);
         block_read_fM_valid  = 1'b0;
         block_write_fM_valid = 1'b0;
         check1("hold_strobe", isWrite ? BlkWrite_2M : BlkRead_2M, 1'b1);
         checkW("hold_addr", BLK_W'(blk_address_2M), BLK_W'(expAddr));
         if (isWrite) checkW("hold_wdata", block_write_2M, expWr);
      end
      block_read_fM = rdData;
      if (isWrite) block_write_fM_valid = 1'b1;
      else         block_read_fM_valid  = 1'b1;
      @(negedge CLK);
      block_read_fM_valid  = 1'b0;
      block_write_fM_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cycles=%0d expected completion", cyc);
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int               c0;
      logic [BLK_W-1:0] blkA, blkB, blkC, wBlk;
      logic [ADDR_W-1:0] a1, a2, a3;

      RESET = 1'b1;
      iReq_fIC = 1'b0; iAddr_fIC = '0;
      dRead_fDC = 1'b0; dWrite_fDC = 1'b0; dAddr_fDC = '0; dBlock_fDC = '0;
      block_read_fM = '0; block_read_fM_valid = 1'b0; block_write_fM_valid = 1'b0;
      modelI = '0; modelD = '0;
      repeat (2) @(negedge CLK);
      checkIdleOutputs("reset");
      RESET = 1'b0;
      @(negedge CLK);

      // Tie after reset: I first, then a new tie goes to D, then I again.
      a1 = 32'h0000_1234; a2 = 32'h0000_8888; a3 = 32'h0000_5677;
      blkA = randBlk(); blkB = randBlk(); blkC = randBlk();
      iReq_fIC = 1'b1; iAddr_fIC = a1; dRead_fDC = 1'b1; dAddr_fDC = a2;
      c0 = cyc;
      expectDone(1'b0, blkA);
      serve(1'b0, blkAddr(a1), '0, 0, blkA, 1'b0);
      modelI = blkA;
      checkI("lat_min", cyc - c0, 2);
      check1("tie1_idone", iDone_2IC, 1'b1);
      iReq_fIC = 1'b0;
      @(negedge CLK);
      iReq_fIC = 1'b1; iAddr_fIC = a3;
      expectDone(1'b1, blkB);
      expectDone(1'b0, blkC);
      serve(1'b0, blkAddr(a2), '0, 1, blkB, 1'b0);
      modelD = blkB;
      dRead_fDC = 1'b0;
      serve(1'b0, blkAddr(a3), '0, 0, blkC, 1'b0);
      modelI = blkC;
      iReq_fIC = 1'b0;
      @(negedge CLK);

      // I only, offset stripped, valid on the second grant cycle, stray write valid ignored.
      blkA = randBlk();
      iReq_fIC = 1'b1; iAddr_fIC = 32'h0040_0024;
      c0 = cyc;
      expectDone(1'b0, blkA);
      serve(1'b0, 32'h0040_0020, '0, 1, blkA, 1'b1);
      modelI = blkA;
      checkI("lat_4cyc", cyc - c0, 3);
      check1("i_done_high", iDone_2IC, 1'b1);
      iReq_fIC = 1'b0;
      @(negedge CLK);
      check1("i_done_one_cycle", iDone_2IC, 1'b0);
      check1("busy_after_i", busy, 1'b0);
      checkW("iblock_hold", iBlock_2IC, modelI);

      // Writeback before refill; address/data changed mid-write must not leak through.
      wBlk = randBlk(); blkB = randBlk();
      dWrite_fDC = 1'b1; dRead_fDC = 1'b1; dAddr_fDC = 32'h1000_0044; dBlock_fDC = wBlk;
      expectDone(1'b1, modelD);
      serve(1'b1, 32'h1000_0040, wBlk, 2, '0, 1'b1);
      check1("wb_ddone", dDone_2DC, 1'b1);
      dWrite_fDC = 1'b0;
      expectDone(1'b1, blkB);
      serve(1'b0, blkAddr(dAddr_fDC), '0, 0, blkB, 1'b0);
      modelD = blkB;
      dRead_fDC = 1'b0;
      @(negedge CLK);

      // Stray valids in IDLE change nothing.
      block_write_fM_valid = 1'b1; block_read_fM_valid = 1'b1; block_read_fM = randBlk();
      @(negedge CLK);
      block_write_fM_valid = 1'b0; block_read_fM_valid = 1'b0;
      check1("stray_busy", busy, 1'b0);
      check1("stray_ddone", dDone_2DC, 1'b0);
      @(negedge CLK);
      check1("stray_busy2", busy, 1'b0);
      checkW("stray_iblock", iBlock_2IC, modelI);
      checkW("stray_dblock", dBlock_2DC, modelD);

      // Reset in the middle of a D read abandons it silently.
      dRead_fDC = 1'b1; dAddr_fDC = 32'h3000_0010;
      waitGrant();
      check1("mid_rd_strobe", BlkRead_2M, 1'b1);
      RESET = 1'b1;
      #1;
      checkIdleOutputs("mid_reset");
      dRead_fDC = 1'b0;
      modelI = '0; modelD = '0;
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      blkC = randBlk();
      iReq_fIC = 1'b1; iAddr_fIC = 32'h0000_0F3C;
      c0 = cyc;
      expectDone(1'b0, blkC);
      serve(1'b0, 32'h0000_0F20, '0, 0, blkC, 1'b0);
      checkI("lat_after_reset", cyc - c0, 2);
      iReq_fIC = 1'b0;
      repeat (3) @(negedge CLK);
      checkW("dblock_after_reset", dBlock_2DC, modelD);
      checkI("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_block_arbiter.md
MEM_BLOCK_ARBITER -- requirements
Module: mem_block_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ADDR_W, 32, block address width.
- BLK_W, 256, cache block width in bits.
- OFF_BITS, 5, block-offset bits forced to zero on the memory address.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- CLK, in, 1, single clock, rising edge.
- RESET, in, 1, asynchronous, active-high.
- iReq_fIC, in, 1, I-cache block-read request.
- iAddr_fIC, in, ADDR_W, I-cache miss address.
- iBlock_2IC, out, BLK_W, block returned to I-cache.
- iDone_2IC, out, 1, one-cycle I completion pulse.
- dRead_fDC, in, 1, D-cache block-read request.
- dWrite_fDC, in, 1, D-cache block-write (writeback) request.
- dAddr_fDC, in, ADDR_W, D-cache address.
- dBlock_fDC, in, BLK_W, writeback data.
- dBlock_2DC, out, BLK_W, block returned to D-cache.
- dDone_2DC, out, 1, one-cycle D completion pulse.
- blk_address_2M, out, ADDR_W, memory block address.
- BlkRead_2M, out, 1, memory block-read request.
- BlkWrite_2M, out, 1, memory block-write request.
- block_write_2M, out, BLK_W, memory write data.
- block_read_fM, in, BLK_W, memory read data.
- block_read_fM_valid, in, 1, read complete.
- block_write_fM_valid, in, 1, write complete.
- busy, out, 1, a transaction is in flight.

Function
REQ-003 FSM states SHALL be IDLE, I_RD, D_RD, D_WR, RESP.
REQ-004 In IDLE with at least one request, the block SHALL select a winner at the clock edge, latch its address (low OFF_BITS zeroed) and, for D_WR, latch dBlock_fDC, then enter the matching grant state.
REQ-005 Priority between I and D SHALL be round-robin: on a tie, the side not granted last wins; last_grant SHALL update on every grant.
REQ-006 Within D, dWrite_fDC SHALL take precedence over dRead_fDC (writeback before refill); the read stays pending.
REQ-007 In I_RD and D_RD, BlkRead_2M SHALL be high; in D_WR, BlkWrite_2M SHALL be high; both SHALL be low in all other states.
REQ-008 blk_address_2M and block_write_2M SHALL be driven from the latched registers and SHALL hold steady for the whole grant state.
REQ-009 The block SHALL remain in a grant state until the matching valid is sampled high; the non-matching valid SHALL be ignored.
REQ-010 On block_read_fM_valid in I_RD or D_RD, block_read_fM SHALL be captured into iBlock_2IC or dBlock_2DC respectively, and the FSM SHALL enter RESP.
REQ-011 In RESP, exactly one of iDone_2IC or dDone_2DC SHALL be high for one cycle; the FSM SHALL then return to IDLE. Requests SHALL be ignored in RESP.
REQ-012 Requesters deassert the serviced request in the cycle after done; a request still high in IDLE SHALL be treated as new.
REQ-013 Minimum latency SHALL be 3 cycles from a request sampled in IDLE to the done pulse, given a valid in the first grant cycle.
REQ-014 iBlock_2IC and dBlock_2DC SHALL hold their last captured value until the next capture.
REQ-015 busy SHALL equal (state != IDLE).
REQ-016 Valid pulses sampled in IDLE or RESP SHALL be ignored.

Reset
REQ-017 Asserting RESET at any time, including mid-transaction, SHALL force IDLE, all request and done outputs to 0, busy to 0, blk_address_2M, block_write_2M, iBlock_2IC and dBlock_2DC to 0, and last_grant to D (so I wins the first tie); any in-flight transfer SHALL be abandoned without a done pulse.

Structure
REQ-018 The state enum, BLK_W and OFF_BITS SHALL live in shared package mem_arb_pkg.
REQ-019 Two-way round-robin selection SHALL be a sub-module rr_pick2 (inputs: req_i, req_d, last_grant; output: grant).

Verification
REQ-020 I only: iReq with iAddr=0x0040_0024, valid on the 2nd grant cycle -> blk_address_2M=0x0040_0020, iBlock_2IC = memory data, iDone one cycle, 4 cycles total.
REQ-021 Tie after reset: iReq and dRead together -> I served first, then D; next tie -> D first.
REQ-022 dWrite and dRead together, dAddr=0x1000_0044 -> BlkWrite with block_write_2M = latched dBlock, dDone, then BlkRead, dDone; read_valid pulses during D_WR are ignored.
REQ-023 dAddr and dBlock changed mid-D_WR -> memory address and data stay at the latched values.
REQ-024 RESET asserted in D_RD before valid -> IDLE immediately, no dDone, all outputs 0; the next iReq completes normally.
REQ-025 Stray block_write_fM_valid in IDLE -> no state change, no done pulse.
